cnn_frame_loader: RTL and testbench

Upstream stage of the CNN core unit. It accepts one image as a 64-beat valid/ready word stream and buffers it into a 64x32 register frame. It then clears and starts the core, waits for the core's done, and returns the core's 32-bit result on a valid/ready result port. It also drops malformed frames and recovers from a hung core with a timeout.

---
 rtl/cnn_pkg.sv | 25 ++
 rtl/cnn_frame_loader_if.sv | 52 +++++
 rtl/img_frame_buffer.sv | 44 ++++
 rtl/cnn_frame_loader.sv | 170 +++++++++++++++++
 tb/tb_cnn_frame_loader.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : cnn_pkg                                                          |
// | Purpose : Shared defaults and the loader state type for the CNN frame      |
// |           loader slice (loader top, frame buffer, handshake interface).    |
// | Contents: c_IMG_WORDS - default words per image frame (8x8 feature map)    |
// |           c_DATA_W    - default pixel / result word width                  |
// |           loader_state_t - loader FSM state encoding                       |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package cnn_pkg;

  localparam int c_IMG_WORDS = 64;
  localparam int c_DATA_W    = 32;

  typedef enum logic [2:0] {
    ST_LOAD   = 3'd0,
    ST_DROP   = 3'd1,
    ST_START  = 3'd2,
    ST_RUN    = 3'd3,
    ST_RESULT = 3'd4
  } loader_state_t;

endpackage : cnn_pkg
`default_nettype wire

// File: rtl/cnn_frame_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : cnn_frame_loader_if                                            |
// | Purpose   : Bundles the three handshake groups of the frame loader.        |
// | Groups    : s_*    - input pixel stream (valid/ready, last marks frame end)|
// |             core_* - control/status towards the CNN core                   |
// |             r_*    - result port (valid/ready) with timeout flag           |
// | Modports  : slave  - loader side (consumes stream, drives core + result)   |
// |             master - environment side (stream source, core, result sink)   |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
interface cnn_frame_loader_if
  import cnn_pkg::*;
#(
  parameter int DATA_W = c_DATA_W
);

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;

  logic              core_clear;
  logic              core_enable;
  logic              core_done;
  logic [DATA_W-1:0] core_value;

  logic              r_valid;
  logic              r_ready;
  logic [DATA_W-1:0] r_value;
  logic              r_timeout;

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready,
    output core_clear, core_enable,
    input  core_done, core_value,
    output r_valid, r_value, r_timeout,
    input  r_ready
  );

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready,
    input  core_clear, core_enable,
    output core_done, core_value,
    input  r_valid, r_value, r_timeout,
    output r_ready
  );

endinterface : cnn_frame_loader_if
`default_nettype wire

// File: rtl/img_frame_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : img_frame_buffer                                                 |
// | Purpose : DEPTH x DATA_W register file with one write port and the whole   |
// |           contents exposed as a flat vector (word i at [DATA_W*i +:DATA_W])|
// | Ports   : clk   - clock, rising edge                                       |
// |           rst   - asynchronous active-low reset, clears every word         |
// |           we    - write enable                                             |
// |           addr  - write word address                                       |
// |           wdata - write data                                               |
// |           flat  - flattened read-out of all words                          |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module img_frame_buffer
  import cnn_pkg::*;
#(
  parameter  int DEPTH    = c_IMG_WORDS,
  parameter  int DATA_W   = c_DATA_W,
  localparam int c_ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [c_ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]       wdata,
  output logic [DEPTH*DATA_W-1:0] flat
);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
    logic [DATA_W-1:0] r_word;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_word <= '0;
      end else if (we && (addr == c_ADDR_W'(gi))) begin
        r_word <= wdata;
      end
    end

    assign flat[DATA_W*gi +: DATA_W] = r_word;
  end : g_word

endmodule : img_frame_buffer
`default_nettype wire

// File: rtl/cnn_frame_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : cnn_frame_loader                                                 |
// | Purpose : Buffers one IMG_WORDS-beat image from a valid/ready stream,      |
// |           pulses core_clear, holds core_enable until core_done (or a       |
// |           timeout), then presents the result on a valid/ready port.        |
// |           Short and long frames are dropped and counted.                   |
// | Ports   : clk           - clock, rising edge                               |
// |           rst           - asynchronous active-low reset                    |
// |           bus           - stream / core / result handshakes (slave view)   |
// |           img_flat      - buffered frame, word i at [DATA_W*i +: DATA_W]   |
// |           frame_err_cnt - saturating count of dropped frames               |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module cnn_frame_loader
  import cnn_pkg::*;
#(
  parameter int IMG_WORDS   = c_IMG_WORDS,
  parameter int DATA_W      = c_DATA_W,
  parameter int TIMEOUT_CYC = 4096,
  parameter int ERR_W       = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  cnn_frame_loader_if.slave           bus,
  output logic [IMG_WORDS*DATA_W-1:0] img_flat,
  output logic [ERR_W-1:0]            frame_err_cnt
);

  localparam int c_IDX_W = (IMG_WORDS > 1) ? $clog2(IMG_WORDS) : 1;
  localparam int c_TMO_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(IMG_WORDS - 1);
  localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYC - 1);

  loader_state_t       r_state;
  logic [c_IDX_W-1:0]  r_wr_idx;
  logic [c_TMO_W-1:0]  r_tmo_cnt;
  logic [ERR_W-1:0]    r_err_cnt;

  // All handshake outputs are flops so that every one of them is 0 during
  // reset; each is loaded with the value belonging to the state being entered.
  logic                r_s_ready;
  logic                r_core_clear;
  logic                r_core_enable;
  logic                r_res_valid;
  logic [DATA_W-1:0]   r_res_value;
  logic                r_res_timeout;

  logic                w_beat;
  logic                w_buf_we;
  logic                w_idx_last;

  assign w_beat     = bus.s_valid && r_s_ready;
  assign w_buf_we   = w_beat && (r_state == ST_LOAD);
  assign w_idx_last = (r_wr_idx == c_IDX_LAST);

  img_frame_buffer #(
    .DEPTH  (IMG_WORDS),
    .DATA_W (DATA_W)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (w_buf_we),
    .addr  (r_wr_idx),
    .wdata (bus.s_data),
    .flat  (img_flat)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_LOAD;
      r_wr_idx      <= '0;
      r_tmo_cnt     <= '0;
      r_err_cnt     <= '0;
      r_s_ready     <= 1'b0;
      r_core_clear  <= 1'b0;
      r_core_enable <= 1'b0;
      r_res_valid   <= 1'b0;
      r_res_value   <= '0;
      r_res_timeout <= 1'b0;
    end else begin
      r_core_clear <= 1'b0;

      case (r_state)
        ST_LOAD: begin
          // Covers the first cycle after reset release, where ready is still 0.
          r_s_ready <= 1'b1;
          if (w_beat) begin
            if (bus.s_last) begin
              r_wr_idx <= '0;
              if (w_idx_last) begin
                r_state      <= ST_START;
                r_s_ready    <= 1'b0;
                r_core_clear <= 1'b1;
              end else if (r_err_cnt != '1) begin
                r_err_cnt <= r_err_cnt + ERR_W'(1);
              end
            end else if (w_idx_last) begin
              // Frame overran the buffer: swallow the rest up to s_last.
              r_state <= ST_DROP;
            end else begin
              r_wr_idx <= r_wr_idx + c_IDX_W'(1);
            end
          end
        end

        ST_DROP: begin
          if (w_beat && bus.s_last) begin
            r_state  <= ST_LOAD;
            r_wr_idx <= '0;
            if (r_err_cnt != '1) begin
              r_err_cnt <= r_err_cnt + ERR_W'(1);
            end
          end
        end

        ST_START: begin
          r_state       <= ST_RUN;
          r_tmo_cnt     <= '0;
          r_core_enable <= 1'b1;
        end

        ST_RUN: begin
          r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
          // A real done wins over a timeout landing in the same cycle.
          if (bus.core_done) begin
            r_state       <= ST_RESULT;
            r_core_enable <= 1'b0;
            r_res_valid   <= 1'b1;
            r_res_value   <= bus.core_value;
            r_res_timeout <= 1'b0;
          end else if (r_tmo_cnt == c_TMO_LAST) begin
            r_state       <= ST_RESULT;
            r_core_enable <= 1'b0;
            r_res_valid   <= 1'b1;
            r_res_value   <= '0;
            r_res_timeout <= 1'b1;
          end
        end

        ST_RESULT: begin
          if (r_res_valid && bus.r_ready) begin
            r_state     <= ST_LOAD;
            r_res_valid <= 1'b0;
            r_s_ready   <= 1'b1;
          end
        end

        default: begin
          r_state       <= ST_LOAD;
          r_wr_idx      <= '0;
          r_s_ready     <= 1'b0;
          r_core_enable <= 1'b0;
          r_res_valid   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s_ready     = r_s_ready;
  assign bus.core_clear  = r_core_clear;
  assign bus.core_enable = r_core_enable;
  assign bus.r_valid     = r_res_valid;
  assign bus.r_value     = r_res_value;
  assign bus.r_timeout   = r_res_timeout;
  assign frame_err_cnt   = r_err_cnt;

endmodule : cnn_frame_loader
`default_nettype wire

// File: tb/tb_cnn_frame_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_cnn_frame_loader                                              |
// | Purpose : Self-checking bench for cnn_frame_loader with a behavioural core |
// |           model and a frame-level reference model (expected buffer words,  |
// |           expected error count, expected result and cycle timing).         |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_cnn_frame_loader;

  localparam int c_WORDS = 64;
  localparam int c_DW    = 32;
  localparam int c_TMO   = 100;
  localparam int c_EW    = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cnn_frame_loader_if #(.DATA_W(c_DW)) bus ();

  logic [c_WORDS*c_DW-1:0] img_flat;
  logic [c_EW-1:0]         frame_err_cnt;

  cnn_frame_loader #(
    .IMG_WORDS   (c_WORDS),
    .DATA_W      (c_DW),
    .TIMEOUT_CYC (c_TMO),
    .ERR_W       (c_EW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus.slave),
    .img_flat      (img_flat),
    .frame_err_cnt (frame_err_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int clr_total = 0;

  logic [c_DW-1:0] frame_data [0:127];
  logic [c_DW-1:0] exp_buf    [0:c_WORDS-1];
  int              exp_err = 0;

  // Behavioural core: raises done core_delay enabled cycles after clear.
  int              core_delay = 20;
  bit              core_hang  = 1'b0;
  logic [c_DW-1:0] core_val   = '0;
  int              core_cnt   = 0;
  logic            core_done_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (rst && bus.core_clear) clr_total <= clr_total + 1;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_cnt    <= 0;
      core_done_q <= 1'b0;
    end else if (bus.core_clear) begin
      core_cnt    <= 0;
      core_done_q <= 1'b0;
    end else if (bus.core_enable && !core_done_q) begin
      core_cnt <= core_cnt + 1;
      if (!core_hang && (core_cnt + 1 == core_delay)) core_done_q <= 1'b1;
    end
  end

  assign bus.core_done  = core_done_q;
  assign bus.core_value = core_val;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_img(input string tag);
    int nbad;
    nbad = 0;
    for (int i = 0; i < c_WORDS; i++)
      if (img_flat[c_DW*i +: c_DW] !== exp_buf[i]) nbad++;
    chk({tag, " img_flat_bad_words"}, nbad, 0);
  endtask

  // Reference model: which words a frame of len beats leaves in the buffer
  // and whether it counts as an error.
  task automatic model_frame(input int len);
    for (int i = 0; i < len && i < c_WORDS; i++) exp_buf[i] = frame_data[i];
    if (len != c_WORDS && exp_err < 255) exp_err++;
  endtask

  // Entered and left at posedge+1.
  task automatic send_frame(input int len, input bit gaps, output int last_cyc);
    int budget;
    last_cyc = -1;
    for (int i = 0; i < len; i++) begin
      budget = 0;
      forever begin
        bus.s_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        bus.s_data  = frame_data[i];
        bus.s_last  = (i == len - 1);
        @(negedge clk);
        if (bus.s_valid && bus.s_ready) begin
          last_cyc = cyc;
          @(posedge clk); #1;
          break;
        end
        @(posedge clk); #1;
        budget++;
        if (budget > 50) begin
          chk("send_accept_wait s_ready", bus.s_ready, 1'b1);
          bus.s_valid = 1'b0;
          return;
        end
      end
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic watch_core(input int limit, output int clr_n, output int clr_c,
                            output int en_f, output int en_n, output int rv_c);
    clr_n = 0; clr_c = -1; en_f = -1; en_n = 0; rv_c = -1;
    for (int t = 0; t < limit; t++) begin
      @(negedge clk);
      if (bus.core_clear) begin clr_n++; clr_c = cyc; end
      if (bus.core_enable) begin
        if (en_f < 0) en_f = cyc;
        en_n++;
      end
      if (bus.r_valid) begin rv_c = cyc; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic handshake(input string tag);
    bus.r_ready = 1'b1;
    @(negedge clk);
    chk({tag, " s_ready_in_result"}, bus.s_ready, 1'b0);
    @(posedge clk); #1;
    bus.r_ready = 1'b0;
    @(negedge clk);
    chk({tag, " r_valid_dropped"}, bus.r_valid, 1'b0);
    chk({tag, " s_ready_back"}, bus.s_ready, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic full_frame(input string tag, input bit gaps, input bit hang,
                            input int delay, input logic [c_DW-1:0] val);
    int lc, cn, cc, ef, en, rc;
    core_hang = hang; core_delay = delay; core_val = val;
    send_frame(c_WORDS, gaps, lc);
    model_frame(c_WORDS);
    watch_core(c_TMO + 50, cn, cc, ef, en, rc);
    chk({tag, " clear_pulses"}, cn, 1);
    chk({tag, " clear_cycle"}, cc, lc + 1);
    chk({tag, " enable_first"}, ef, lc + 2);
    chk({tag, " enable_cycles"}, en, hang ? c_TMO : delay + 1);
    chk({tag, " r_valid_cycle"}, rc, hang ? lc + 2 + c_TMO : lc + 3 + delay);
    chk({tag, " r_value"}, bus.r_value, hang ? '0 : val);
    chk({tag, " r_timeout"}, bus.r_timeout, hang);
    chk({tag, " enable_in_result"}, bus.core_enable, 1'b0);
    chk_img(tag);
    handshake(tag);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lc, len, kind, bad, rise_c, acc, clr0;
    logic [c_DW-1:0] held, bp_word;

    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0; bus.r_ready = 1'b0;
    for (int i = 0; i < c_WORDS; i++) exp_buf[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset s_ready", bus.s_ready, 1'b0);
    chk("reset core_clear", bus.core_clear, 1'b0);
    chk("reset core_enable", bus.core_enable, 1'b0);
    chk("reset r_valid", bus.r_valid, 1'b0);
    chk("reset r_value", bus.r_value, '0);
    chk("reset r_timeout", bus.r_timeout, 1'b0);
    chk("reset frame_err_cnt", frame_err_cnt, exp_err);
    chk_img("reset");
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_reset s_ready", bus.s_ready, 1'b1);
    @(posedge clk); #1;

    // Nominal frame
    for (int i = 0; i < c_WORDS; i++) frame_data[i] = 32'(3 * i);
    full_frame("nominal", 1'b0, 1'b0, 20, 32'h0000_1234);
    chk("nominal word63", img_flat[63*c_DW +: c_DW], 32'd189);

    // Short frame then a good frame
    for (int i = 0; i < 10; i++) frame_data[i] = $urandom;
    clr0 = clr_total;
    send_frame(10, 1'b0, lc);
    model_frame(10);
    chk("short no_clear", clr_total, clr0);
    chk("short frame_err_cnt", frame_err_cnt, exp_err);
    chk_img("short");
    for (int i = 0; i < c_WORDS; i++) frame_data[i] = $urandom;
    full_frame("after_short", 1'b0, 1'b0, 7, $urandom);
    chk("after_short word0", img_flat[c_DW-1:0], frame_data[0]);

    // Long frame
    for (int i = 0; i < 70; i++) frame_data[i] = $urandom;
    clr0 = clr_total;
    send_frame(70, 1'b0, lc);
    model_frame(70);
    @(negedge clk);
    chk("long frame_err_cnt", frame_err_cnt, exp_err);
    chk("long s_ready", bus.s_ready, 1'b1);
    chk("long core_enable", bus.core_enable, 1'b0);
    @(posedge clk); #1;
    chk("long no_clear", clr_total, clr0);
    chk_img("long");

    // Result backpressure with a pending input beat
    for (int i = 0; i < c_WORDS; i++) frame_data[i] = $urandom;
    core_hang = 1'b0; core_delay = 5; core_val = $urandom;
    send_frame(c_WORDS, 1'b0, lc);
    model_frame(c_WORDS);
    begin
      int cn, cc, ef, en, rc;
      watch_core(c_TMO + 50, cn, cc, ef, en, rc);
      chk("bp r_valid_cycle", rc, lc + 8);
    end
    bp_word = $urandom;
    bus.s_valid = 1'b1; bus.s_data = bp_word; bus.s_last = 1'b1;
    held = core_val;
    bad = 0;
    for (int t = 0; t < 15; t++) begin
      @(negedge clk);
      if (bus.r_valid !== 1'b1 || bus.r_value !== held || bus.s_ready !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    chk("bp stall_violations", bad, 0);
    chk_img("bp_stall");
    bus.r_ready = 1'b1;
    rise_c = cyc;
    acc = -1;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (bus.s_valid && bus.s_ready && acc < 0) acc = cyc;
      @(posedge clk); #1;
      bus.r_ready = 1'b0;
      if (acc >= 0) break;
    end
    bus.s_valid = 1'b0; bus.s_last = 1'b0;
    chk("bp accept_cycle", acc, rise_c + 1);
    frame_data[0] = bp_word;
    model_frame(1);
    chk("bp frame_err_cnt", frame_err_cnt, exp_err);
    chk_img("bp_after");

    // Timeout
    for (int i = 0; i < c_WORDS; i++) frame_data[i] = $urandom;
    full_frame("timeout", 1'b0, 1'b1, 0, $urandom);

    // Randomized frames
    for (int f = 0; f < 6; f++) begin
      kind = $urandom_range(0, 2);
      len  = (kind == 0) ? $urandom_range(1, 63) :
             (kind == 1) ? c_WORDS : $urandom_range(65, 75);
      for (int i = 0; i < len; i++) frame_data[i] = $urandom;
      if (len == c_WORDS) begin
        full_frame("rand_full", 1'b1, 1'b0, $urandom_range(1, 60), $urandom);
      end else begin
        clr0 = clr_total;
        send_frame(len, 1'b1, lc);
        model_frame(len);
        @(negedge clk);
        chk("rand_bad frame_err_cnt", frame_err_cnt, exp_err);
        chk("rand_bad s_ready", bus.s_ready, 1'b1);
        @(posedge clk); #1;
        chk("rand_bad no_clear", clr_total, clr0);
        chk_img("rand_bad");
      end
    end

    // Error counter saturation
    for (int n = 0; n < 260; n++) begin
      frame_data[0] = $urandom;
      send_frame(1, 1'b0, lc);
      model_frame(1);
    end
    chk("sat frame_err_cnt", frame_err_cnt, exp_err);
    chk("sat at max", frame_err_cnt, 8'd255);
    chk_img("sat");

    // Reset while the core is running
    for (int i = 0; i < c_WORDS; i++) frame_data[i] = $urandom;
    core_hang = 1'b0; core_delay = 50; core_val = $urandom;
    send_frame(c_WORDS, 1'b0, lc);
    model_frame(c_WORDS);
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("pre_reset core_enable", bus.core_enable, 1'b1);
    #2; rst = 1'b0; #1;
    exp_err = 0;
    for (int i = 0; i < c_WORDS; i++) exp_buf[i] = '0;
    chk("async_reset core_enable", bus.core_enable, 1'b0);
    chk("async_reset r_valid", bus.r_valid, 1'b0);
    chk("async_reset s_ready", bus.s_ready, 1'b0);
    chk("async_reset frame_err_cnt", frame_err_cnt, exp_err);
    chk_img("async_reset");
    repeat (2) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("release s_ready", bus.s_ready, 1'b1);
    @(posedge clk); #1;
    for (int i = 0; i < c_WORDS; i++) frame_data[i] = 32'(3 * i);
    full_frame("post_reset", 1'b0, 1'b0, 20, 32'h0000_1234);
    chk("post_reset frame_err_cnt", frame_err_cnt, exp_err);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_cnn_frame_loader
`default_nettype wire
